alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Lets two requesters share one external ALU. A three-state FSM
//   (IDLE -> EXEC -> RESP) accepts one operation at a time. The winner's
//   opcode and operands are latched on grant and drive the ALU from
//   registers only. The ALU result and flags are captured at the end of
//   EXEC, and the winner gets a single-cycle done pulse in RESP. Requests
//   that arrive together are granted round-robin.
//
// Ports:
//   CLK                  clock, rising-edge active
//   RST                  asynchronous, active-high reset
//   req0 / req1          operation request from requester 0 / 1
//   op0 / op1            4-bit ALU opcode from requester 0 / 1
//   a0, b0 / a1, b1      operands A/B from requester 0 / 1
//   done0 / done1        one-cycle completion pulse to requester 0 / 1
//   result               captured ALU result of the last completed operation
//   neg, ovf, zero       captured ALU flags of the last completed operation
//   busy                 high whenever the FSM is not in IDLE
//   alu_opcode           opcode driven to the shared ALU
//   alu_portA/alu_portB  operands driven to the shared ALU
//   alu_outPort          result returned by the ALU
//   alu_negative/alu_overflow/alu_zero  flags returned by the ALU
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,

  input  logic              req0,
  input  logic              req1,
  input  logic [3:0]        op0,
  input  logic [3:0]        op1,
  input  logic [WORD_W-1:0] a0,
  input  logic [WORD_W-1:0] b0,
  input  logic [WORD_W-1:0] a1,
  input  logic [WORD_W-1:0] b1,

  output logic              done0,
  output logic              done1,
  output logic [WORD_W-1:0] result,
  output logic              neg,
  output logic              ovf,
  output logic              zero,
  output logic              busy,

  output logic [3:0]        alu_opcode,
  output logic [WORD_W-1:0] alu_portA,
  output logic [WORD_W-1:0] alu_portB,
  input  logic [WORD_W-1:0] alu_outPort,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;

  // Arbitration: id of the requester served last, and of the in-flight winner.
  logic                last_q, last_d;
  logic                win_q, win_d;

  // Latched operation; these registers are the only source for the ALU ports.
  logic [3:0]          op_q, op_d;
  logic [WORD_W-1:0]   a_q, a_d;
  logic [WORD_W-1:0]   b_q, b_d;

  // Captured ALU response, held until the next EXEC.
  logic [WORD_W-1:0]   result_q, result_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic                zero_q, zero_d;

  logic                grant_id;

  // A lone requester wins outright. On a tie, the requester that was not
  // served last wins.
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic last);
    logic w;
    if (r0 && r1) begin
      w = ~last;
    end else begin
      w = r1;
    end
    return w;
  endfunction

  assign grant_id = pick_winner(req0, req1, last_q);

  // Next-state and datapath-next logic
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d   = grant_id;
          last_d  = grant_id;
          op_d    = grant_id ? op1 : op0;
          a_d     = grant_id ? a1  : a0;
          b_d     = grant_id ? b1  : b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // The ALU sees only the latched operands during this cycle, so its
        // outputs are stable at this edge.
        result_d = alu_outPort;
        neg_d    = alu_negative;
        ovf_d    = alu_overflow;
        zero_d   = alu_zero;
        state_d  = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and register update
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      // Pointing at requester 1 makes requester 0 win the first tie.
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // Done is decoded from registered state, so only one line can be high and
  // reset clears it at once.
  assign done0      = (state_q == RESP) && !win_q;
  assign done1      = (state_q == RESP) &&  win_q;
  assign busy       = (state_q != IDLE);

  assign result     = result_q;
  assign neg        = neg_q;
  assign ovf        = ovf_q;
  assign zero       = zero_q;

  assign alu_opcode = op_q;
  assign alu_portA  = a_q;
  assign alu_portB  = b_q;

endmodule
